// File: rtl/clock_div_detector.sv
// Recovers the power-of-2 divide code (period 4..512 clk cycles) of an asynchronous clk_in.
// Optional 50% duty qualification is enabled by defining CLOCK_DIV_DETECTOR_DUTY_CHECK_EN.
module clock_div_detector #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_COUNT  = 2,
    parameter int unsigned CNT_W       = 10
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             en,
    input  logic             clk_in,
    output logic [2:0]       div_code,
    output logic             locked,
    output logic [CNT_W-1:0] period,
    output logic             err,
    output logic             stall
);
    localparam int unsigned PW      = CNT_W + 1;
    localparam int unsigned MW      = 4;
    localparam int unsigned TIMEOUT = 512;

    typedef enum logic [1:0] {IDLE, ALIGN, MEASURE, LOCKED} state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d;
    logic                   rise;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [PW-1:0]          p_meas;
    logic                   p_pow2;
    logic [2:0]             p_code;
    logic                   p_ok;
    logic                   timeout;
    logic [MW-1:0]          match, match_n;
    logic [2:0]             candidate, candidate_n, div_code_n;
    logic                   locked_n, err_n, stall_n;
    logic [CNT_W-1:0]       period_n;

    // Synchronizer plus one extra flop for edge detection
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            sync_q <= '0;
            sync_d <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], clk_in};
            sync_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise    = sync_q[SYNC_STAGES-1] & ~sync_d;
    assign p_meas  = PW'(cnt) + PW'(1);
    // Next count would reach 512 without a rise; a rise always wins
    assign timeout = (cnt == CNT_W'(TIMEOUT - 1)) && !rise;

    always_comb begin
        p_pow2 = 1'b0;
        p_code = '0;
        for (int k = 0; k < 8; k++) begin
            if (p_meas == (PW'(4) << k)) begin
                p_pow2 = 1'b1;
                p_code = 3'(k);
            end
        end
    end

`ifdef CLOCK_DIV_DETECTOR_DUTY_CHECK_EN
    logic          fall;
    logic          fall_seen;
    logic [PW-1:0] high_q;

    assign fall = ~sync_q[SYNC_STAGES-1] & sync_d;

    // High time is the count from the last rise up to and including the fall cycle
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            fall_seen <= 1'b0;
            high_q    <= '0;
        end else if (rise) begin
            fall_seen <= 1'b0;
        end else if (fall) begin
            fall_seen <= 1'b1;
            high_q    <= p_meas;
        end
    end

    assign p_ok = p_pow2 && fall_seen && ({high_q, 1'b0} == {1'b0, p_meas});
`else
    assign p_ok = p_pow2;
`endif

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state     <= IDLE;
            cnt       <= '0;
            match     <= '0;
            candidate <= '0;
            div_code  <= '0;
            locked    <= 1'b0;
            period    <= '0;
            err       <= 1'b0;
            stall     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            match     <= match_n;
            candidate <= candidate_n;
            div_code  <= div_code_n;
            locked    <= locked_n;
            period    <= period_n;
            err       <= err_n;
            stall     <= stall_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        match_n     = match;
        candidate_n = candidate;
        div_code_n  = div_code;
        locked_n    = locked;
        period_n    = period;
        err_n       = 1'b0;
        stall_n     = stall;

        if (rise) begin
            cnt_n   = '0;
            stall_n = 1'b0;
        end else if (cnt != '1) begin
            cnt_n = cnt + CNT_W'(1);
        end

        case (state)
            IDLE: begin
                cnt_n    = '0;
                locked_n = 1'b0;
                stall_n  = 1'b0;
                if (en) state_n = ALIGN;
            end
            ALIGN: begin
                if (rise) begin
                    match_n = '0;
                    state_n = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    period_n = CNT_W'(p_meas);
                    if (!p_ok) begin
                        err_n   = 1'b1;
                        match_n = '0;
                    end else begin
                        if (p_code == candidate) begin
                            match_n = match + MW'(1);
                        end else begin
                            candidate_n = p_code;
                            match_n     = MW'(1);
                        end
                        if (match_n >= MW'(LOCK_COUNT)) begin
                            div_code_n = candidate_n;
                            locked_n   = 1'b1;
                            state_n    = LOCKED;
                        end
                    end
                end else if (timeout) begin
                    err_n    = 1'b1;
                    stall_n  = 1'b1;
                    locked_n = 1'b0;
                    state_n  = ALIGN;
                end
            end
            LOCKED: begin
                if (rise) begin
                    period_n = CNT_W'(p_meas);
                    if (!(p_ok && (p_code == div_code))) begin
                        err_n    = 1'b1;
                        locked_n = 1'b0;
                        state_n  = MEASURE;
                        if (p_ok) begin
                            candidate_n = p_code;
                            match_n     = MW'(1);
                        end else begin
                            match_n = '0;
                        end
                    end
                end else if (timeout) begin
                    err_n    = 1'b1;
                    stall_n  = 1'b1;
                    locked_n = 1'b0;
                    state_n  = ALIGN;
                end
            end
            default: state_n = IDLE;
        endcase

        // Disable overrides everything; div_code is deliberately kept
        if (!en) begin
            state_n  = IDLE;
            cnt_n    = '0;
            match_n  = '0;
            locked_n = 1'b0;
            stall_n  = 1'b0;
            err_n    = 1'b0;
            period_n = '0;
        end
    end
endmodule

// File: tb/tb_clock_div_detector.sv
// Directed bench for clock_div_detector: lock, code changes, illegal periods, timeout, en/rst_.
// Duty-cycle case follows CLOCK_DIV_DETECTOR_DUTY_CHECK_EN.
module tb_clock_div_detector;
    localparam int unsigned CNT_W = 10;

    logic             clk = 1'b0;
    logic             rst_;
    logic             en;
    logic             clk_in;
    logic [2:0]       div_code;
    logic             locked;
    logic [CNT_W-1:0] period;
    logic             err;
    logic             stall;

    int checks    = 0;
    int errors    = 0;
    int err_cnt   = 0;
    int stall_cnt = 0;

    clock_div_detector #(.SYNC_STAGES(2), .LOCK_COUNT(2), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_     (rst_),
        .en       (en),
        .clk_in   (clk_in),
        .div_code (div_code),
        .locked   (locked),
        .period   (period),
        .err      (err),
        .stall    (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n clocks, landing 1 time unit after each edge; tally err/stall pulses
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (err === 1'b1) err_cnt++;
            if (stall === 1'b1) stall_cnt++;
        end
    endtask

    // n periods of length p with high time h, each starting with a rising edge
    task automatic wave(input int p, input int h, input int n);
        repeat (n) begin
            clk_in = 1'b1;
            tick(h);
            clk_in = 1'b0;
            tick(p - h);
        end
    endtask

    initial begin
        rst_   = 1'b0;
        en     = 1'b0;
        clk_in = 1'b0;
        tick(2);
        check("rst_div_code", 32'(div_code), 0);
        check("rst_locked",   32'(locked),   0);
        check("rst_period",   32'(period),   0);
        check("rst_err",      32'(err),      0);
        check("rst_stall",    32'(stall),    0);
        rst_ = 1'b1;
        tick(2);

        // P=16: lock appears exactly one cycle after the 3rd rise is detected
        en = 1'b1;
        tick(2);
        err_cnt = 0; stall_cnt = 0;
        wave(16, 8, 2);
        clk_in = 1'b1;
        tick(2);
        check("p16_not_yet_locked", 32'(locked), 0);
        tick(1);
        check("p16_locked",   32'(locked),   1);
        check("p16_div_code", 32'(div_code), 2);
        check("p16_period",   32'(period),   16);
        tick(5);
        clk_in = 1'b0;
        tick(8);
        wave(16, 8, 2);
        check("p16_still_locked", 32'(locked), 1);
        check("p16_no_err",       32'(err_cnt), 0);

        // P=4 (code 0): one err on the first short period, then relock
        err_cnt = 0;
        wave(4, 2, 6);
        check("p4_locked",   32'(locked),   1);
        check("p4_div_code", 32'(div_code), 0);
        check("p4_period",   32'(period),   4);
        check("p4_err_cnt",  32'(err_cnt),  1);

        // P=512 (code 7): longest legal period must not time out
        err_cnt = 0;
        wave(512, 256, 3);
        check("p512_locked",   32'(locked),    1);
        check("p512_div_code", 32'(div_code),  7);
        check("p512_period",   32'(period),    512);
        check("p512_err_cnt",  32'(err_cnt),   1);
        check("p512_no_stall", 32'(stall_cnt), 0);

        // Lock on P=8, then switch to P=32
        err_cnt = 0;
        wave(8, 4, 4);
        check("p8_locked",   32'(locked),   1);
        check("p8_div_code", 32'(div_code), 1);
        err_cnt = 0;
        wave(32, 16, 2);
        check("p32_unlocked", 32'(locked),  0);
        check("p32_one_err",  32'(err_cnt), 1);
        wave(32, 16, 2);
        check("p32_locked",   32'(locked),   1);
        check("p32_div_code", 32'(div_code), 3);
        check("p32_period",   32'(period),   32);
        check("p32_err_cnt",  32'(err_cnt),  1);

        // P=12 is illegal: err on every rise, never locks
        err_cnt = 0;
        wave(12, 6, 6);
        check("p12_err_cnt", 32'(err_cnt), 5);
        check("p12_locked",  32'(locked),  0);
        check("p12_period",  32'(period),  12);

        // Lock on P=64, then hold clk_in low for a timeout
        err_cnt = 0;
        wave(64, 32, 4);
        check("p64_locked",   32'(locked),   1);
        check("p64_div_code", 32'(div_code), 4);
        tick(450);
        check("to_stall_early", 32'(stall), 0);
        check("to_err_early",   32'(err),   0);
        tick(1);
        check("to_stall",  32'(stall),  1);
        check("to_err",    32'(err),    1);
        check("to_locked", 32'(locked), 0);
        tick(1);
        check("to_err_pulse_end", 32'(err),   0);
        check("to_stall_held",    32'(stall), 1);
        wave(64, 32, 1);
        check("to_stall_cleared", 32'(stall), 0);
        wave(64, 32, 3);
        check("to_relocked", 32'(locked),   1);
        check("to_div_code", 32'(div_code), 4);

        // en drop mid-lock: next cycle cleared, div_code kept
        en = 1'b0;
        tick(1);
        check("en_locked",   32'(locked),   0);
        check("en_stall",    32'(stall),    0);
        check("en_err",      32'(err),      0);
        check("en_div_code", 32'(div_code), 4);
        en = 1'b1;
        tick(2);
        err_cnt = 0;
        wave(8, 4, 4);
        check("en_relocked",  32'(locked),   1);
        check("en_relock_dc", 32'(div_code), 1);
        check("en_no_err",    32'(err_cnt),  0);

        // Asynchronous reset mid-lock, checked between clock edges
        rst_ = 1'b0;
        #2;
        check("arst_div_code", 32'(div_code), 0);
        check("arst_locked",   32'(locked),   0);
        check("arst_period",   32'(period),   0);
        check("arst_stall",    32'(stall),    0);
        tick(1);
        rst_ = 1'b1;
        tick(2);
        wave(16, 8, 4);
        check("arst_relocked", 32'(locked),   1);
        check("arst_div_code2", 32'(div_code), 2);

        // 25% duty P=16
        err_cnt = 0;
        wave(16, 4, 6);
        check("duty_period", 32'(period), 16);
`ifdef CLOCK_DIV_DETECTOR_DUTY_CHECK_EN
        check("duty_err_cnt", 32'(err_cnt), 5);
        check("duty_locked",  32'(locked),  0);
`else
        check("duty_err_cnt", 32'(err_cnt), 0);
        check("duty_locked",  32'(locked),  1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
